// File: rtl/dual_port_bram.sv
// dual_port_bram
//
// True dual-port RAM on a single clock. Both ports read and write one shared
// storage array independently. The default 512 x 8 geometry holds one disk
// sector. The sector loader uses it as a buffer:
//   - port A faces the SD-card block interface;
//   - port B faces the emulated disk controller.
//
// Ports:
//   clk         sole clock, rising edge
//   reset       synchronous, active-high
//   address_a   port A word address
//   wren_a      port A write enable
//   data_a      port A write data
//   q_a         port A registered read data (1-cycle latency)
//   address_b   port B word address
//   wren_b      port B write enable
//   data_b      port B write data
//   q_b         port B registered read data (1-cycle latency)
//   init_busy   high while the reset-triggered clear sweep is running
//   state_dbg   current controller state (0 = RUN, 1 = CLEAR)
//
// Handshake: there is none. address/wren/data are sampled on every rising
// edge, and q_x is valid from one edge until the next.
//
// Port rules:
//   - Each port is write-first on itself.
//   - Each port is read-old across ports.
//   - On a same-address double write, port A wins.

module dual_port_bram #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 9,
    parameter int INIT_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] address_a,
    input  logic                  wren_a,
    input  logic [DATA_WIDTH-1:0] data_a,
    output logic [DATA_WIDTH-1:0] q_a,
    input  logic [ADDR_WIDTH-1:0] address_b,
    input  logic                  wren_b,
    input  logic [DATA_WIDTH-1:0] data_b,
    output logic [DATA_WIDTH-1:0] q_b,
    output logic                  init_busy,
    output logic                  state_dbg
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {
        RUN   = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   clr_cnt;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    // Port B's write is dropped when port A writes the same word in the
    // same cycle, so the stored value never depends on assignment order.
    logic                    wr_a_en;
    logic                    wr_b_en;

    always_comb begin
        wr_a_en = 1'b0;
        wr_b_en = 1'b0;
        if (!reset && state == RUN) begin
            wr_a_en = wren_a;
            wr_b_en = wren_b && !(wren_a && (address_a == address_b));
        end
    end

    assign state_dbg = state;

    // Storage array: clear sweep writes, or the two port writes.
    always_ff @(posedge clk) begin
        if (!reset && state == CLEAR) begin
            mem[clr_cnt] <= '0;
        end else begin
            if (wr_b_en) begin
                mem[address_b] <= data_b;
            end
            if (wr_a_en) begin
                mem[address_a] <= data_a;
            end
        end
    end

    // Controller and registered read outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_a     <= '0;
            q_b     <= '0;
            clr_cnt <= '0;
            if (INIT_ON_RESET != 0) begin
                state     <= CLEAR;
                init_busy <= 1'b1;
            end else begin
                state     <= RUN;
                init_busy <= 1'b0;
            end
        end else begin
            case (state)
                CLEAR: begin
                    q_a     <= '0;
                    q_b     <= '0;
                    clr_cnt <= clr_cnt + ADDR_WIDTH'(1);
                    // The edge that clears the final word also leaves CLEAR.
                    if (clr_cnt == LAST_ADDR) begin
                        state     <= RUN;
                        init_busy <= 1'b0;
                    end
                end
                default: begin
                    // A same-port write bypasses the array (write-first).
                    // A cross-port read samples the array before this
                    // edge's write lands (read-old).
                    q_a <= wren_a ? data_a : mem[address_a];
                    q_b <= wren_b ? data_b : mem[address_b];
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dual_port_bram.sv
// tb_dual_port_bram
//
// Directed bench for dual_port_bram with its default 512 x 8 geometry.
// Inputs change 1 time unit after a rising edge. Outputs are sampled at
// that same point.

module tb_dual_port_bram;

    logic       clk;
    logic       reset;
    logic [8:0] address_a;
    logic       wren_a;
    logic [7:0] data_a;
    logic [7:0] q_a;
    logic [8:0] address_b;
    logic       wren_b;
    logic [7:0] data_b;
    logic [7:0] q_b;
    logic       init_busy;
    logic       state_dbg;

    int checks;
    int errors;
    int n;

    dual_port_bram #(
        .DATA_WIDTH    (8),
        .ADDR_WIDTH    (9),
        .INIT_ON_RESET (1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .address_a (address_a),
        .wren_a    (wren_a),
        .data_a    (data_a),
        .q_a       (q_a),
        .address_b (address_b),
        .wren_b    (wren_b),
        .data_b    (data_b),
        .q_b       (q_b),
        .init_busy (init_busy),
        .state_dbg (state_dbg)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs,
                         input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Hold reset low and count the cycles that init_busy stays high.
    // The count is bounded at 1000 cycles.
    task automatic count_busy(output int cnt);
        cnt = 0;
        while (init_busy === 1'b1 && cnt < 1000) begin
            tick();
            cnt++;
            if (cnt == 10) begin
                check("clear_q_a_zero", {8'h0, q_a}, 16'h0);
                check("clear_q_b_zero", {8'h0, q_b}, 16'h0);
            end
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b1;
        address_a = '0;
        address_b = '0;
        wren_a    = 1'b0;
        wren_b    = 1'b0;
        data_a    = '0;
        data_b    = '0;

        // Reset state
        tick();
        tick();
        check("reset_q_a",       {8'h0, q_a}, 16'h0);
        check("reset_q_b",       {8'h0, q_b}, 16'h0);
        check("reset_init_busy", {15'h0, init_busy}, 16'h1);
        check("reset_state",     {15'h0, state_dbg}, 16'h1);

        // Clear sweep. Writes attempted during the sweep must not persist.
        reset     = 1'b0;
        wren_a    = 1'b1;
        address_a = 9'd255;
        data_a    = 8'hFF;
        wren_b    = 1'b1;
        address_b = 9'd511;
        data_b    = 8'h77;
        count_busy(n);
        check("clear_cycles", 16'(n), 16'd512);
        check("run_state",    {15'h0, state_dbg}, 16'h0);
        wren_a = 1'b0;
        wren_b = 1'b0;

        // Cleared contents at 0, 255 and 511, read on both ports.
        address_a = 9'd0;   address_b = 9'd255; tick();
        check("clr_a_0",   {8'h0, q_a}, 16'h0);
        check("clr_b_255", {8'h0, q_b}, 16'h0);
        address_a = 9'd511; address_b = 9'd0;   tick();
        check("clr_a_511", {8'h0, q_a}, 16'h0);
        check("clr_b_0",   {8'h0, q_b}, 16'h0);
        address_a = 9'd255; address_b = 9'd511; tick();
        check("clr_a_255", {8'h0, q_a}, 16'h0);
        check("clr_b_511", {8'h0, q_b}, 16'h0);

        // Port A write, then port B reads it on the next cycle.
        wren_a = 1'b1; address_a = 9'h010; data_a = 8'hA5; tick();
        check("a_write_first", {8'h0, q_a}, 16'hA5);
        wren_a = 1'b0; address_b = 9'h010; tick();
        check("b_read_after_a", {8'h0, q_b}, 16'hA5);

        // Both ports write 0x1FF in one cycle: A wins in storage.
        wren_a = 1'b1; address_a = 9'h1FF; data_a = 8'h11;
        wren_b = 1'b1; address_b = 9'h1FF; data_b = 8'h22; tick();
        check("dual_wr_q_a", {8'h0, q_a}, 16'h11);
        check("dual_wr_q_b", {8'h0, q_b}, 16'h22);
        wren_a = 1'b0; wren_b = 1'b0; tick();
        check("dual_rd_q_a", {8'h0, q_a}, 16'h11);
        check("dual_rd_q_b", {8'h0, q_b}, 16'h11);

        // Same-port write-first vs cross-port read-old.
        wren_a = 1'b1; address_a = 9'd5; data_a = 8'h33; tick();
        data_a = 8'h44; address_b = 9'd5; tick();
        check("wf_q_a", {8'h0, q_a}, 16'h44);
        check("ro_q_b", {8'h0, q_b}, 16'h33);
        wren_a = 1'b0; tick();
        check("ro_next_q_b", {8'h0, q_b}, 16'h44);

        // Sector round trip: A fills, B reads back with 1-cycle latency.
        wren_a = 1'b1;
        for (int i = 0; i < 512; i++) begin
            address_a = 9'(i);
            data_a    = 8'(i);
            tick();
        end
        wren_a = 1'b0;
        for (int i = 0; i < 512; i++) begin
            address_b = 9'(i);
            tick();
            check("sector_q_b", {8'h0, q_b}, {8'h0, 8'(i)});
        end

        // Reset at cycle 100 of a clear restarts the sweep from address 0.
        reset = 1'b1; tick();
        check("rst2_q_b", {8'h0, q_b}, 16'h0);
        reset = 1'b0;
        for (int i = 0; i < 100; i++) tick();
        check("mid_clear_busy", {15'h0, init_busy}, 16'h1);
        reset = 1'b1; tick();
        reset = 1'b0;
        count_busy(n);
        check("restart_clear_cycles", 16'(n), 16'd512);

        // Final sweep: every word reads back as zero on both ports.
        for (int i = 0; i < 512; i++) begin
            address_a = 9'(i);
            address_b = 9'(511 - i);
            tick();
            check("final_q_a", {8'h0, q_a}, 16'h0);
            check("final_q_b", {8'h0, q_b}, 16'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dual_port_bram.md
# dual_port_bram

Synchronous true dual-port RAM, single clock: two independent read/write ports share one storage array. Default geometry is 512 × 8, one disk sector. One port faces the SD-card block interface; the other faces the emulated disk controller. The sector loader uses it as its single-sector buffer between the SD image and the drive logic.

## Interface
Parameters:
- DATA_WIDTH, 8, word width in bits.
- ADDR_WIDTH, 9, address width; depth is 2^ADDR_WIDTH words.
- INIT_ON_RESET, 1, when 1, reset triggers a sequential clear of all words to 0.

Ports:
- clk  in  1  sole clock; all ports sample on its rising edge.
- reset  in  1  synchronous, active-high; sampled on rising edge of clk.
- address_a  in  ADDR_WIDTH  port A word address.
- wren_a  in  1  port A write enable.
- data_a  in  DATA_WIDTH  port A write data.
- q_a  out  DATA_WIDTH  port A registered read data.
- address_b  in  ADDR_WIDTH  port B word address.
- wren_b  in  1  port B write enable.
- data_b  in  DATA_WIDTH  port B write data.
- q_b  out  DATA_WIDTH  port B registered read data.
- init_busy  out  1  high while the reset-triggered clear is running.

## Operation
- States: RUN and CLEAR.
- Reset, all cases: q_a = 0, q_b = 0, clear counter = 0.
- Reset with INIT_ON_RESET=1: enter CLEAR, init_busy = 1.
- Reset with INIT_ON_RESET=0: stay in RUN, init_busy = 0, memory contents preserved.
- CLEAR: one word per cycle is written to 0, addresses 0 up to 2^ADDR_WIDTH−1.
  - Port writes are ignored and q_a/q_b hold 0.
  - After the last address is written, go to RUN and drop init_busy.
  - The clear takes exactly 2^ADDR_WIDTH cycles.
- Reset asserted mid-CLEAR restarts the clear from address 0.
- RUN, each port independently every cycle:
  - If wren_x, mem[address_x] <= data_x.
  - q_x <= read of mem[address_x].
- Same-port read during write is write-first: q_x shows data_x on the next cycle.
- Cross-port read of an address the other port writes in the same cycle is read-old: it returns the pre-write contents.
- Both ports write the same address in the same cycle: port A's data is stored, port B's is discarded. Each port's q follows its own same-port rule: q_a = data_a, q_b = data_b.
- Addresses are exactly ADDR_WIDTH bits and there is no out-of-range case. Data is stored unmodified.
- Contents are undefined after power-up until the first write or clear. The bench treats them as X.

## Timing
- Read latency is 1 cycle: address presented at edge N gives q valid after edge N+1, held until the next edge.
- A write at edge N is visible to the other port for a read issued at edge N+1, with data on q at N+2.
- q_a/q_b update every cycle; there is no read enable.
- init_busy asserts on the edge reset is sampled. It deasserts on the edge that writes the final address.
- With default parameters, init_busy is high for 512 cycles after reset is released.
- No handshake: wren/data/address are sampled only on the clock edge.

## Test plan
- Reset with INIT_ON_RESET=1, then hold reset low and wait: init_busy high for exactly 512 cycles. Afterwards, reading addresses 0, 255 and 511 on both ports gives 0x00. Writes attempted during CLEAR do not persist.
- Port A writes 0xA5 at address 0x010, then port B reads 0x010 the next cycle: q_b = 0xA5 one cycle after the read.
- Both ports write address 0x1FF in one cycle (A = 0x11, B = 0x22), then both read 0x1FF: q_a = q_b = 0x11.
- mem[5] = 0x33. In one cycle, port A writes 0x44 to address 5 while port B reads address 5: q_a = 0x44 (write-first) and q_b = 0x33 (read-old). The next read on B returns 0x44.
- Sector round trip: port A writes byte i = i[7:0] for addresses 0–511 on consecutive cycles. Port B then reads 0–511 back-to-back: q_b sequence is 0x00..0xFF twice, with 1-cycle latency.
- Assert reset at cycle 100 of a clear: init_busy stays high for 512 cycles counted from reset release. A final sweep of all addresses returns 0.
